rv_rf_wr_arbiter: RTL and testbench
===================================

RV_RF_WR_ARBITER -- requirements
Module: rv_rf_wr_arbiter

Interface
REQ-001 SHALL have parameter: MAX_WAIT, default 4, the number of cycles requester 1 may be blocked before it is forced; legal range 1..15.
REQ-002 SHALL have port: i_wa_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: i_wa_rst  input  1  synchronous reset, active-high.
REQ-004 SHALL have ports: i_wa_vld0  input  1  writeback request from the pipeline; i_wa_addr0  input  5  destination register; i_wa_data0  input  XLEN  write data; o_wa_rdy0  output  1  accept.
REQ-005 SHALL have ports: i_wa_vld1  input  1  writeback request from the long-latency unit; i_wa_addr1  input  5  destination register; i_wa_data1  input  XLEN  write data; o_wa_rdy1  output  1  accept.
REQ-006 SHALL have ports: o_wa_rf_wen  output  1, o_wa_rf_waddr  output  5, o_wa_rf_wdata  output  XLEN; these drive the register-file write port directly.
REQ-007 SHALL have port: o_wa_starve  output  1  high while the arbiter is in ST_FORCE1.

Function
REQ-008 SHALL complete a transfer on port n in any cycle where vld_n and rdy_n are both high; at most one transfer per cycle.
REQ-009 SHALL implement a 2-state FSM: ST_PRI0 (the normal state) and ST_FORCE1.
REQ-010 In ST_PRI0: rdy0 = 1, and rdy1 = !vld0, so port 0 has fixed priority.
REQ-011 In ST_FORCE1: rdy0 = 0, and rdy1 = 1.
REQ-012 SHALL keep wait_cnt (4 bits); it increments when vld1 is high and rdy1 is low; it clears on any port-1 transfer or whenever vld1 is low; it saturates at MAX_WAIT.
REQ-013 Transition ST_PRI0 -> ST_FORCE1 when vld1, !rdy1 and wait_cnt == MAX_WAIT-1 in the same cycle.
REQ-014 Transition ST_FORCE1 -> ST_PRI0 on a port-1 transfer or when vld1 is low; the arbiter SHALL stay in ST_FORCE1 for no more than one cycle when vld1 is held.
REQ-015 SHALL register the winning request: o_wa_rf_waddr and o_wa_rf_wdata are valid exactly one cycle after the transfer, with o_wa_rf_wen high for exactly that cycle.
REQ-016 o_wa_rf_wen SHALL be low in cycles with no transfer in the previous cycle; waddr and wdata then hold their last values.
REQ-017 A transfer with addr == 0 SHALL complete the handshake but leave o_wa_rf_wen low, since x0 is never written.
REQ-018 Ready signals SHALL be combinational from state and vld0 only, never from vld1 and never from the data or address inputs.
REQ-019 A requester SHALL hold vld, addr and data stable until accepted; the arbiter need not detect violations.
REQ-020 Back-to-back transfers SHALL be sustained at 1 per cycle with no bubble.

Reset
REQ-021 While i_wa_rst is high at a clock edge: state = ST_PRI0, wait_cnt = 0, o_wa_rf_wen = 0, o_wa_rf_waddr = 0, o_wa_rf_wdata = 0, o_wa_starve = 0.
REQ-022 During reset, the rdy outputs SHALL follow REQ-010 from the reset state, but transfers in that cycle SHALL be discarded and not written.
REQ-023 Reset asserted while a registered write is pending SHALL cancel that write: o_wa_rf_wen is 0 in the following cycle.

Structure
REQ-024 XLEN and the FSM state enum (ST_PRI0, ST_FORCE1) SHALL live in the shared package rv_pkg; MAX_WAIT is a module parameter.
REQ-025 The block SHALL be a single module with no sub-modules; the register file is instantiated beside it by the parent, not inside it.

Verification
REQ-026 Port 0 only: vld0=1, addr0=5, data0=0xDEADBEEF for 1 cycle -> next cycle wen=1, waddr=5, wdata=0xDEADBEEF; the cycle after that, wen=0.
REQ-027 Both ports valid with MAX_WAIT=4 (vld0 held, addr0=1; vld1 held, addr1=2) -> rdy1 low for 4 cycles with o_wa_starve=0; 5th cycle: o_wa_starve=1, rdy0=0, rdy1=1; addr 2 written the next cycle; then port 0 resumes.
REQ-028 x0 write: vld1=1, addr1=0, data1=0x12345678, vld0=0 -> rdy1=1 and the transfer completes, but wen stays 0.
REQ-029 Streaming: vld0=1 for 8 cycles with addr 1..8 -> wen high for 8 consecutive cycles, addrs 1..8 in order, no bubble.
REQ-030 Reset mid-operation: transfer addr0=7 in cycle N, assert i_wa_rst at edge N+1 -> wen=0 after that edge, state ST_PRI0, wait_cnt=0.
REQ-031 Starvation abort: enter ST_FORCE1, then drop vld1 -> return to ST_PRI0 next cycle, wait_cnt=0, and rdy0 high again.

Source files
------------

// File: rtl/rv_pkg.sv
// rv_pkg: shared core types for the register-file writeback path.
package rv_pkg;
  localparam int XLEN = 32;
  typedef enum logic {ST_PRI0 = 1'b0, ST_FORCE1 = 1'b1} wa_state_e;
endpackage

// File: rtl/rv_rf_wr_arbiter.sv
// rv_rf_wr_arbiter: two-port register-file writeback arbiter, port 0 priority with a starvation guard for port 1.
module rv_rf_wr_arbiter
  import rv_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic            i_wa_clk,
  input  logic            i_wa_rst,
  input  logic            i_wa_vld0,
  input  logic [4:0]      i_wa_addr0,
  input  logic [XLEN-1:0] i_wa_data0,
  output logic            o_wa_rdy0,
  input  logic            i_wa_vld1,
  input  logic [4:0]      i_wa_addr1,
  input  logic [XLEN-1:0] i_wa_data1,
  output logic            o_wa_rdy1,
  output logic            o_wa_rf_wen,
  output logic [4:0]      o_wa_rf_waddr,
  output logic [XLEN-1:0] o_wa_rf_wdata,
  output logic            o_wa_starve
);
  wa_state_e       state_q, state_d;
  logic [3:0]      wait_q, wait_d;
  logic            wen_q;
  logic [4:0]      waddr_q;
  logic [XLEN-1:0] wdata_q;
  logic            xfer0, xfer1, blk1, wr0, wr1;
  assign xfer0 = i_wa_vld0 & o_wa_rdy0;
  assign xfer1 = i_wa_vld1 & o_wa_rdy1;
  assign blk1  = i_wa_vld1 & ~o_wa_rdy1;
  // x0 transfers still handshake but never reach the register file
  assign wr0   = xfer0 & (i_wa_addr0 != 5'd0);
  assign wr1   = xfer1 & (i_wa_addr1 != 5'd0);
  always_ff @(posedge i_wa_clk) begin
    if (i_wa_rst) begin
      state_q <= ST_PRI0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end
  always_comb begin
    state_d = (state_q == ST_PRI0)
            ? ((blk1 && wait_q == 4'(MAX_WAIT - 1)) ? ST_FORCE1 : ST_PRI0)
            : ((xfer1 || !i_wa_vld1) ? ST_PRI0 : ST_FORCE1);
    wait_d  = (!i_wa_vld1 || xfer1) ? 4'd0
            : (wait_q == 4'(MAX_WAIT)) ? wait_q : wait_q + 4'd1;
  end
  always_comb begin
    o_wa_rdy0   = state_q == ST_PRI0;
    o_wa_rdy1   = (state_q == ST_FORCE1) || !i_wa_vld0;
    o_wa_starve = state_q == ST_FORCE1;
  end
  always_ff @(posedge i_wa_clk) begin
    if (i_wa_rst) begin
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      wen_q <= wr0 | wr1;
      if (wr0 | wr1) begin
        waddr_q <= wr0 ? i_wa_addr0 : i_wa_addr1;
        wdata_q <= wr0 ? i_wa_data0 : i_wa_data1;
      end
    end
  end
  assign o_wa_rf_wen   = wen_q;
  assign o_wa_rf_waddr = waddr_q;
  assign o_wa_rf_wdata = wdata_q;
endmodule

// File: tb/tb_rv_rf_wr_arbiter.sv
// tb_rv_rf_wr_arbiter: directed table, corner sequences and randomized traffic against a behavioural model.
module tb_rv_rf_wr_arbiter;
  import rv_pkg::*;
  localparam int MW = 4;
  logic clk = 1'b0;
  logic rst, vld0, vld1, rdy0, rdy1, wen, starve;
  logic [4:0] addr0, addr1, waddr;
  logic [XLEN-1:0] data0, data1, wdata;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  rv_rf_wr_arbiter #(.MAX_WAIT(MW)) dut (
    .i_wa_clk(clk), .i_wa_rst(rst),
    .i_wa_vld0(vld0), .i_wa_addr0(addr0), .i_wa_data0(data0), .o_wa_rdy0(rdy0),
    .i_wa_vld1(vld1), .i_wa_addr1(addr1), .i_wa_data1(data1), .o_wa_rdy1(rdy1),
    .o_wa_rf_wen(wen), .o_wa_rf_waddr(waddr), .o_wa_rf_wdata(wdata), .o_wa_starve(starve)
  );
  // model: port 1 is forced once it has sat blocked for MW consecutive cycles
  bit m_ok = 0, m_force = 0, m_wen = 0, m_x0 = 0, m_x1 = 0;
  int m_waited = 0;
  logic [4:0] m_addr = '0;
  logic [XLEN-1:0] m_data = '0;
  typedef struct {
    logic v0; logic [4:0] a0; logic [31:0] d0;
    logic v1; logic [4:0] a1; logic [31:0] d1;
    logic r0; logic r1; logic st; logic we; logic [4:0] wa; logic [31:0] wd;
  } vec_t;
  vec_t tab[14];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", n, act, exp, $time);
    end
  endtask
  task automatic set_in(input logic r, input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                        input logic v1, input logic [4:0] a1, input logic [31:0] d1);
    rst = r; vld0 = v0; addr0 = a0; data0 = d0; vld1 = v1; addr1 = a1; data1 = d1;
  endtask
  task automatic model_check();
    if (!m_ok) return;
    chk("m_rdy0", rdy0, !m_force);
    chk("m_rdy1", rdy1, m_force || !vld0);
    chk("m_starve", starve, m_force);
    chk("m_wen", wen, m_wen);
    chk("m_waddr", waddr, m_addr);
    chk("m_wdata", wdata, m_data);
  endtask
  task automatic model_step();
    m_x0 = vld0 && !m_force;
    m_x1 = vld1 && (m_force || !vld0);
    if (rst) begin
      m_ok = 1; m_force = 0; m_waited = 0; m_wen = 0; m_addr = '0; m_data = '0;
    end else begin
      m_wen = (m_x0 && addr0 != 0) || (m_x1 && addr1 != 0);
      if (m_x0 && addr0 != 0) begin m_addr = addr0; m_data = data0; end
      else if (m_x1 && addr1 != 0) begin m_addr = addr1; m_data = data1; end
      m_waited = (vld1 && !m_x1) ? m_waited + 1 : 0;
      m_force = m_waited >= MW;
    end
  endtask
  task automatic finish_cycle();
    model_check();
    model_step();
    @(posedge clk);
    #1;
  endtask
  // hold both ports valid until starvation shows; n = cycles port 1 saw rdy low
  task automatic count_blocked(output int n, output bit found);
    n = 0; found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      set_in(0, 1, 5'd4, 32'h44, 1, 5'd6, 32'h66);
      @(negedge clk);
      if (starve) found = 1;
      else begin
        if (!rdy1) n++;
        finish_cycle();
      end
    end
    chk("force_reached", found, 1'b1);
  endtask
  initial begin
    int n;
    bit found;
    bit acc0, acc1;
    tab[0]  = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0};
    tab[1]  = '{1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    tab[2]  = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 5, 32'hDEADBEEF};
    tab[3]  = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 5, 32'hDEADBEEF};
    tab[4]  = '{0, 0, 0, 1, 0, 32'h12345678, 1, 1, 0, 0, 5, 32'hDEADBEEF};
    tab[5]  = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 5, 32'hDEADBEEF};
    tab[6]  = '{1, 1, 32'hA1A1A1A1, 1, 2, 32'hB2B2B2B2, 1, 0, 0, 0, 5, 32'hDEADBEEF};
    tab[7]  = '{1, 1, 32'hA1A1A1A1, 1, 2, 32'hB2B2B2B2, 1, 0, 0, 1, 1, 32'hA1A1A1A1};
    tab[8]  = '{1, 1, 32'hA1A1A1A1, 1, 2, 32'hB2B2B2B2, 1, 0, 0, 1, 1, 32'hA1A1A1A1};
    tab[9]  = '{1, 1, 32'hA1A1A1A1, 1, 2, 32'hB2B2B2B2, 1, 0, 0, 1, 1, 32'hA1A1A1A1};
    tab[10] = '{1, 1, 32'hA1A1A1A1, 1, 2, 32'hB2B2B2B2, 0, 1, 1, 1, 1, 32'hA1A1A1A1};
    tab[11] = '{1, 1, 32'hA1A1A1A1, 0, 0, 0, 1, 0, 0, 1, 2, 32'hB2B2B2B2};
    tab[12] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 1, 32'hA1A1A1A1};
    tab[13] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 32'hA1A1A1A1};
    set_in(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      finish_cycle();
    end
    for (int i = 0; i < 14; i++) begin
      set_in(0, tab[i].v0, tab[i].a0, tab[i].d0, tab[i].v1, tab[i].a1, tab[i].d1);
      @(negedge clk);
      chk($sformatf("tab%0d_rdy0", i), rdy0, tab[i].r0);
      chk($sformatf("tab%0d_rdy1", i), rdy1, tab[i].r1);
      chk($sformatf("tab%0d_starve", i), starve, tab[i].st);
      chk($sformatf("tab%0d_wen", i), wen, tab[i].we);
      chk($sformatf("tab%0d_waddr", i), waddr, tab[i].wa);
      chk($sformatf("tab%0d_wdata", i), wdata, tab[i].wd);
      finish_cycle();
    end
    for (int k = 1; k <= 10; k++) begin
      if (k <= 8) set_in(0, 1, 5'(k), 32'(k * 32'h1111), 0, 0, 0);
      else set_in(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      if (k >= 2 && k <= 9) begin
        chk($sformatf("stream%0d_wen", k - 1), wen, 1'b1);
        chk($sformatf("stream%0d_waddr", k - 1), waddr, 5'(k - 1));
      end
      if (k == 10) chk("stream_end_wen", wen, 1'b0);
      finish_cycle();
    end
    set_in(1, 1, 5'd9, 32'h99, 0, 0, 0);
    @(negedge clk);
    finish_cycle();
    set_in(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rst_discard_wen", wen, 1'b0);
    finish_cycle();
    set_in(0, 1, 5'd7, 32'h77, 1, 5'd3, 32'h33);
    @(negedge clk);
    finish_cycle();
    set_in(1, 0, 0, 0, 1, 5'd3, 32'h33);
    @(negedge clk);
    chk("pend_wen", wen, 1'b1);
    chk("pend_waddr", waddr, 5'd7);
    finish_cycle();
    set_in(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rst_cancel_wen", wen, 1'b0);
    chk("rst_waddr", waddr, 5'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_starve", starve, 1'b0);
    chk("rst_rdy0", rdy0, 1'b1);
    finish_cycle();
    count_blocked(n, found);
    chk("blocked_after_rst", n, MW);
    finish_cycle();
    set_in(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("force_write_wen", wen, 1'b1);
    chk("force_write_waddr", waddr, 5'd6);
    finish_cycle();
    count_blocked(n, found);
    chk("blocked_before_abort", n, MW);
    vld1 = 1'b0;
    finish_cycle();
    set_in(0, 1, 5'd4, 32'h44, 0, 0, 0);
    @(negedge clk);
    chk("abort_rdy0", rdy0, 1'b1);
    chk("abort_starve", starve, 1'b0);
    finish_cycle();
    count_blocked(n, found);
    chk("blocked_after_abort", n, MW);
    finish_cycle();
    acc0 = 1; acc1 = 1;
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(0, 99) == 0;
      if (!vld0 || acc0) begin
        vld0 = $urandom_range(0, 3) != 0;
        addr0 = 5'($urandom); data0 = $urandom;
      end
      if (!vld1 || acc1) begin
        vld1 = $urandom_range(0, 1) != 0;
        addr1 = 5'($urandom); data1 = $urandom;
      end else if ($urandom_range(0, 15) == 0) vld1 = 1'b0;
      @(negedge clk);
      finish_cycle();
      acc0 = m_x0; acc1 = m_x1;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end
endmodule
